// File: rtl/not_result_checker.sv
// Self-checking monitor for the bitwise-NOT unit: recomputes ~a for each accepted pair,
// keeps saturating pass/fail counts and captures the first failing pair. Optional: NOT_CHECK_HALT_EN.
module not_result_checker #(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_out,
  output logic             busy,
  output logic             halted,
  output logic             err_seen,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [N-1:0]     first_a,
  output logic [N-1:0]     first_out
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             err_seen_q, err_seen_d;
  logic [N-1:0]     first_a_q, first_a_d;
  logic [N-1:0]     first_out_q, first_out_d;
  logic             ready_c, accept_c, match_c;

  always_comb begin
    state_d     = state_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    err_seen_d  = err_seen_q;
    first_a_d   = first_a_q;
    first_out_d = first_out_q;
    // Control pulses own the cycle, so no pair is taken alongside them.
    ready_c     = (state_q == S_RUN) && !start && !stop;
    accept_c    = in_valid && ready_c;
    match_c     = (in_out == ~in_a);

    if (start) begin
      state_d     = S_RUN;
      pass_cnt_d  = '0;
      fail_cnt_d  = '0;
      err_seen_d  = 1'b0;
      first_a_d   = '0;
      first_out_d = '0;
    end else if (stop) begin
      state_d = S_IDLE;
    end else if (accept_c) begin
      if (match_c) begin
        if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_ONE;
      end else begin
        if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_ONE;
        err_seen_d = 1'b1;
        if (!err_seen_q) begin
          first_a_d   = in_a;
          first_out_d = in_out;
        end
`ifdef NOT_CHECK_HALT_EN
        state_d = S_HALT;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      err_seen_q  <= 1'b0;
      first_a_q   <= '0;
      first_out_q <= '0;
    end else begin
      state_q     <= state_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      err_seen_q  <= err_seen_d;
      first_a_q   <= first_a_d;
      first_out_q <= first_out_d;
    end
  end

  assign in_ready  = ready_c;
  assign busy      = (state_q == S_RUN);
`ifdef NOT_CHECK_HALT_EN
  assign halted    = (state_q == S_HALT);
`else
  assign halted    = 1'b0;
`endif
  assign err_seen  = err_seen_q;
  assign pass_cnt  = pass_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign first_a   = first_a_q;
  assign first_out = first_out_q;

endmodule

// File: tb/tb_not_result_checker.sv
// Bench for not_result_checker: a 16-bit and a 2-bit counter instance share stimulus and
// are checked against a behavioural model of the checker's statistics.
module tb_not_result_checker;

`ifdef NOT_CHECK_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, in_valid = 1'b0;
  logic [3:0] in_a = '0, in_out = '0;

  logic        in_ready, busy, halted, err_seen;
  logic [15:0] pass_cnt, fail_cnt;
  logic [3:0]  first_a, first_out;
  logic        in_ready_s, busy_s, halted_s, err_seen_s;
  logic [1:0]  pass_cnt_s, fail_cnt_s;
  logic [3:0]  first_a_s, first_out_s;

  not_result_checker #(.N(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_out(in_out), .busy(busy), .halted(halted),
    .err_seen(err_seen), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_a(first_a), .first_out(first_out));

  not_result_checker #(.N(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .in_ready(in_ready_s), .in_a(in_a), .in_out(in_out), .busy(busy_s), .halted(halted_s),
    .err_seen(err_seen_s), .pass_cnt(pass_cnt_s), .fail_cnt(fail_cnt_s),
    .first_a(first_a_s), .first_out(first_out_s));

  always #5 clk = ~clk;

  wire [42:0] obs16 = {busy, halted, err_seen, pass_cnt, fail_cnt, first_a, first_out};
  wire [14:0] obs2  = {busy_s, halted_s, err_seen_s, pass_cnt_s, fail_cnt_s, first_a_s, first_out_s};

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 idle, 1 run, 2 halt; raw counts saturate only when compared.
  int         m_mode = 0;
  int         m_pass = 0, m_fail = 0;
  bit         m_err = 1'b0;
  logic [3:0] m_fa = '0, m_fo = '0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [42:0] m_vec16();
    return {m_mode == 1, m_mode == 2, m_err, 16'(sat(m_pass, 65535)), 16'(sat(m_fail, 65535)), m_fa, m_fo};
  endfunction

  function automatic logic [14:0] m_vec2();
    return {m_mode == 1, m_mode == 2, m_err, 2'(sat(m_pass, 3)), 2'(sat(m_fail, 3)), m_fa, m_fo};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pass = 0; m_fail = 0; m_err = 1'b0; m_fa = '0; m_fo = '0;
  endtask

  // Drive one cycle starting just after a rising edge; returns in_ready seen before the edge.
  task automatic apply(input bit s, input bit p, input bit v, input logic [3:0] a, input logic [3:0] o,
                       output bit obs_rdy, output bit obs_rdy_s, output bit exp_rdy);
    logic [3:0] inv;
    start = s; stop = p; in_valid = v; in_a = a; in_out = o;
    #1;
    obs_rdy   = in_ready;
    obs_rdy_s = in_ready_s;
    exp_rdy   = (m_mode == 1) && !s && !p;
    @(posedge clk);
    inv = ~a;
    if (s) begin
      model_reset();
      m_mode = 1;
    end else if (p) begin
      m_mode = 0;
    end else if (exp_rdy && v) begin
      if (o == inv) m_pass++;
      else begin
        m_fail++;
        if (!m_err) begin m_fa = a; m_fo = o; end
        m_err = 1'b1;
        if (HALT_EN) m_mode = 2;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if (obs16 !== 43'd0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset16: got %h rdy %b, want 0 rdy 0", obs16, in_ready);
    end
    n_checks++;
    if (obs2 !== 15'd0 || in_ready_s !== 1'b0) begin
      n_fail++; $display("FAIL reset2: got %h rdy %b, want 0 rdy 0", obs2, in_ready_s);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    bit r, rs, er;
    int bad_rdy = 0;
    apply(1, 0, 0, 4'h0, 4'h0, r, rs, er);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] a;
      a = 4'(i);
      apply(0, 0, 1, a, ~a, r, rs, er);
      if (r !== er || r !== 1'b1) bad_rdy++;
    end
    n_checks++;
    if (bad_rdy != 0) begin
      n_fail++; $display("FAIL stream_ready: %0d cycles with in_ready low, want 0", bad_rdy);
    end
    n_checks++;
    if (pass_cnt !== 16'd16 || fail_cnt !== 16'd0 || err_seen !== 1'b0) begin
      n_fail++; $display("FAIL stream_counts: pass %0d fail %0d err %b, want 16 0 0", pass_cnt, fail_cnt, err_seen);
    end
    n_checks++;
    if (obs16 !== m_vec16()) begin
      n_fail++; $display("FAIL stream_model: got %h want %h", obs16, m_vec16());
    end
  endtask

  task automatic test_mismatch();
    bit r, rs, er;
    apply(1, 0, 0, 4'h0, 4'h0, r, rs, er);
    apply(0, 0, 1, 4'h3, 4'hC, r, rs, er);
    apply(0, 0, 1, 4'h5, 4'h5, r, rs, er);
    n_checks++;
    if (halted !== HALT_EN) begin
      n_fail++; $display("FAIL halt_entry: halted %b, want %b", halted, HALT_EN);
    end
    apply(0, 0, 1, 4'h9, 4'h0, r, rs, er);
    n_checks++;
    if (r !== !HALT_EN) begin
      n_fail++; $display("FAIL third_ready: in_ready %b, want %b", r, !HALT_EN);
    end
    n_checks++;
    if (pass_cnt !== 16'd1 || fail_cnt !== (HALT_EN ? 16'd1 : 16'd2) ||
        first_a !== 4'h5 || first_out !== 4'h5 || err_seen !== 1'b1) begin
      n_fail++; $display("FAIL mismatch_stats: pass %0d fail %0d first %h/%h err %b, want 1 %0d 5/5 1",
                         pass_cnt, fail_cnt, first_a, first_out, err_seen, HALT_EN ? 1 : 2);
    end
    n_checks++;
    if (obs16 !== m_vec16()) begin
      n_fail++; $display("FAIL mismatch_model: got %h want %h", obs16, m_vec16());
    end
  endtask

  task automatic test_saturation();
    bit r, rs, er;
    apply(1, 0, 0, 4'h0, 4'h0, r, rs, er);
    for (int i = 0; i < 5; i++) apply(0, 0, 1, 4'(i + 2), ~4'(i + 2), r, rs, er);
    n_checks++;
    if (pass_cnt_s !== 2'd3 || pass_cnt !== 16'd5) begin
      n_fail++; $display("FAIL saturate: small %0d big %0d, want 3 5", pass_cnt_s, pass_cnt);
    end
    apply(1, 0, 0, 4'h0, 4'h0, r, rs, er);
    n_checks++;
    if (obs2 !== 15'b100_00_00_0000_0000 || obs16 !== m_vec16()) begin
      n_fail++; $display("FAIL restart_clear: small %h big %h, want busy only", obs2, obs16);
    end
  endtask

  task automatic test_ctrl_collision();
    bit r, rs, er;
    apply(1, 0, 0, 4'h0, 4'h0, r, rs, er);
    apply(0, 0, 1, 4'hA, 4'h5, r, rs, er);
    apply(1, 0, 1, 4'h1, 4'hE, r, rs, er);
    n_checks++;
    if (r !== 1'b0 || pass_cnt !== 16'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL start_collide: rdy %b pass %0d busy %b, want 0 0 1", r, pass_cnt, busy);
    end
    apply(0, 0, 1, 4'h6, 4'h9, r, rs, er);
    apply(0, 1, 1, 4'h7, 4'h8, r, rs, er);
    n_checks++;
    if (r !== 1'b0 || busy !== 1'b0 || pass_cnt !== 16'd1) begin
      n_fail++; $display("FAIL stop_collide: rdy %b busy %b pass %0d, want 0 0 1", r, busy, pass_cnt);
    end
    apply(0, 0, 1, 4'h7, 4'h8, r, rs, er);
    n_checks++;
    if (obs16 !== m_vec16() || r !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold: got %h rdy %b, want %h rdy 0", obs16, r, m_vec16());
    end
  endtask

  task automatic test_async_reset();
    bit r, rs, er;
    apply(1, 0, 0, 4'h0, 4'h0, r, rs, er);
    for (int i = 0; i < 3; i++) apply(0, 0, 1, 4'(i), ~4'(i), r, rs, er);
    in_valid = 1'b1; in_a = 4'hB; in_out = 4'h4;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs16 !== 43'd0 || obs2 !== 15'd0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: big %h small %h rdy %b, want 0", obs16, obs2, in_ready);
    end
    #14 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || pass_cnt !== 16'd0) begin
      n_fail++; $display("FAIL post_reset: rdy %b busy %b pass %0d, want 0 0 0", in_ready, busy, pass_cnt);
    end
    apply(0, 0, 0, 4'h0, 4'h0, r, rs, er);
  endtask

  task automatic test_random();
    bit r, rs, er;
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      bit s, p, v;
      logic [3:0] a, o;
      s = ($urandom % 20) == 0;
      p = ($urandom % 25) == 0;
      v = ($urandom % 4) != 0;
      a = 4'($urandom);
      o = (($urandom % 5) == 0) ? 4'($urandom) : ~a;
      apply(s, p, v, a, o, r, rs, er);
      n_checks++;
      if (r !== er || rs !== er || obs16 !== m_vec16() || obs2 !== m_vec2()) begin
        n_fail++;
        if (bad < 5) $display("FAIL random[%0d]: rdy %b/%b big %h small %h, want rdy %b big %h small %h",
                              i, r, rs, obs16, obs2, er, m_vec16(), m_vec2());
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mismatch();
    test_saturation();
    test_ctrl_collision();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
